// File: rtl/light_phase_ctrl.sv
// Red Light, Green Light sequencer: alternates GREEN/RED phases whose lengths
// come from the LFSR, checks for motion in RED after a grace window, and
// reports caught / win. Every output is a flop.
module light_phase_ctrl #(
  parameter int MIN_TICKS   = 4,
  parameter int GRACE_TICKS = 2,
  parameter int NUM_ROUNDS  = 8,
  parameter int ROUND_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               tick,
  input  logic [3:0]         lfsr_in,
  input  logic               move,
  output logic               lfsr_step,
  output logic               green,
  output logic               red,
  output logic               caught,
  output logic               win,
  output logic [ROUND_W-1:0] round
);

  // Duration counter must reach MIN_TICKS+15; grace counter must reach GRACE_TICKS.
  localparam int DUR_W = $clog2(MIN_TICKS + 16);
  localparam int GR_W  = (GRACE_TICKS < 1) ? 1 : $clog2(GRACE_TICKS + 1);

  typedef enum logic [2:0] {S_IDLE, S_GREEN, S_RED, S_CAUGHT, S_WIN} state_t;

  state_t             state, state_nxt;
  logic [DUR_W-1:0]   dur, dur_nxt;
  logic [GR_W-1:0]    grace, grace_nxt;
  logic [ROUND_W-1:0] round_nxt, round_inc;
  logic               load;
  logic               grace_done, last_tick;
  logic [DUR_W-1:0]   phase_len;
  logic               green_nxt, red_nxt, caught_nxt, win_nxt, step_nxt;

  assign phase_len  = DUR_W'(MIN_TICKS) + DUR_W'(lfsr_in);
  assign grace_done = (grace == GR_W'(GRACE_TICKS));
  assign last_tick  = tick && (dur == DUR_W'(1));
  assign round_inc  = round + ROUND_W'(1);

  // State, counters and registered outputs; reset acts without a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      dur       <= '0;
      grace     <= '0;
      round     <= '0;
      green     <= 1'b0;
      red       <= 1'b0;
      caught    <= 1'b0;
      win       <= 1'b0;
      lfsr_step <= 1'b0;
    end else begin
      state     <= state_nxt;
      dur       <= dur_nxt;
      grace     <= grace_nxt;
      round     <= round_nxt;
      green     <= green_nxt;
      red       <= red_nxt;
      caught    <= caught_nxt;
      win       <= win_nxt;
      lfsr_step <= step_nxt;
    end
  end

  // Next state and counter updates; a phase entry reloads the duration and
  // clears grace, so the tick causing the transition is never counted twice.
  always_comb begin
    state_nxt = state;
    dur_nxt   = dur;
    grace_nxt = grace;
    round_nxt = round;
    load      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_GREEN;
          load      = 1'b1;
          round_nxt = '0;
        end
      end
      S_GREEN: begin
        if (last_tick) begin
          state_nxt = S_RED;
          load      = 1'b1;
        end else if (tick) begin
          dur_nxt = dur - DUR_W'(1);
        end
      end
      S_RED: begin
        // Valid motion beats the final tick: no round credit.
        if (move && grace_done) begin
          state_nxt = S_CAUGHT;
        end else if (last_tick) begin
          round_nxt = round_inc;
          if (round_inc == ROUND_W'(NUM_ROUNDS)) begin
            state_nxt = S_WIN;
          end else begin
            state_nxt = S_GREEN;
            load      = 1'b1;
          end
        end else if (tick) begin
          dur_nxt = dur - DUR_W'(1);
          if (!grace_done) grace_nxt = grace + GR_W'(1);
        end
      end
      S_CAUGHT, S_WIN: begin
        if (start) begin
          state_nxt = S_GREEN;
          load      = 1'b1;
          round_nxt = '0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (load) begin
      dur_nxt   = phase_len;
      grace_nxt = '0;
    end
  end

  // Output decode from the upcoming state so lights change with the state flop.
  always_comb begin
    green_nxt  = (state_nxt == S_GREEN) || (state_nxt == S_WIN);
    red_nxt    = (state_nxt == S_RED)   || (state_nxt == S_CAUGHT);
    caught_nxt = (state_nxt == S_CAUGHT);
    win_nxt    = (state_nxt == S_WIN);
    step_nxt   = load;
  end

endmodule
